// File: rtl/uart_pkg.sv
// Shared types for the uart_fifo peripheral: parity mode, TX/RX state encodings,
// and the parity helper used by both directions.
package uart_pkg;

    localparam int UART_MAX_DATA_BITS = 8;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_GUARD  = 3'd0,
        TX_IDLE   = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
        TX_PARITY = 3'd4,
        TX_STOP   = 3'd5
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Bit that makes the total number of ones odd or even; data above DATA_BITS must be zero.
    function automatic logic parity_bit(input logic [UART_MAX_DATA_BITS-1:0] data,
                                        input parity_e par);
        return (par == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with registered empty/full flags; a pop on a full
// FIFO frees the slot for a push in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty_q, full_q;
    logic             do_push, do_pop;

    assign do_pop  = pop & ~empty_q;
    assign do_push = push & (~full_q | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/uart_fifo.sv
// Full-duplex UART with TX/RX FIFOs, configurable frame format and sticky errors.
// Optional UART_FIFO_LOOPBACK_EN adds loopback_i to feed tx_o back into the receiver.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int FREQ_HZ    = 12000000,
    parameter int BAUDS      = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_ni,
    output logic       tx_o,
    input  logic       rx_i,
`ifdef UART_FIFO_LOOPBACK_EN
    input  logic       loopback_i,
`endif
    input  logic       wr_i,
    input  logic [7:0] tx_data_i,
    input  logic       rd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       tx_full_o,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o,
    input  logic       clear_err_i,
    output logic [2:0] tx_state_o,
    output logic [2:0] rx_state_o
);

    localparam int             DIV        = FREQ_HZ / BAUDS;
    localparam int             CW         = $clog2(DIV);
    localparam int             MB         = UART_MAX_DATA_BITS;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_HALF   = CW'(DIV / 2);
    localparam logic [3:0]     DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [3:0]     GUARD_LAST = 4'd9;
    localparam parity_e        PAR        = parity_e'(PARITY);

    // Handshake: wr_i/rd_i are single-cycle strobes; a push is taken when the FIFO
    // is not full (or popped that cycle), a pop only when the FIFO is not empty.

    logic [DATA_BITS-1:0] tx_fifo_dout;
    logic                 tx_fifo_empty, tx_fifo_full, tx_pop;
    logic [DATA_BITS-1:0] rx_fifo_dout;
    logic                 rx_fifo_empty, rx_fifo_full;
    logic [MB-1:0]        tx_head;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .reset_ni (reset_ni),
        .push     (wr_i),
        .pop      (tx_pop),
        .din      (tx_data_i[DATA_BITS-1:0]),
        .dout     (tx_fifo_dout),
        .empty    (tx_fifo_empty),
        .full     (tx_fifo_full)
    );

    assign tx_head = MB'(tx_fifo_dout);

    // ---------------- transmitter ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [MB-1:0] tx_shift_q, tx_shift_d;
    logic          tx_par_q, tx_par_d;
    logic          tx_q, tx_d;
    logic          tx_tick, tx_start;

    assign tx_tick = (tx_cnt_q == CNT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_start   = 1'b0;
        tx_pop     = 1'b0;
        if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        case (tx_state_q)
            TX_GUARD: begin
                tx_d = 1'b1;
                if (tx_tick) begin
                    if (tx_bit_q == GUARD_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            TX_IDLE: tx_start = ~tx_fifo_empty;
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
                        if (PAR != PAR_NONE) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_bit_q == STOP_LAST) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (!tx_fifo_empty) tx_start = 1'b1;
                        else                tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_start) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = parity_bit(tx_head, PAR);
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            tx_state_q <= TX_GUARD;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    // ---------------- receiver ----------------
    logic rx_line;
`ifdef UART_FIFO_LOOPBACK_EN
    assign rx_line = loopback_i ? tx_q : rx_i;
`else
    assign rx_line = rx_i;
`endif

    logic          sync1_q, sync2_q, rx_prev_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [MB-1:0] rx_shift_q, rx_shift_d;
    logic          rx_par_q, rx_par_d;
    logic          rx_tick, rx_done;
    logic          frame_set, parity_set, overrun_set;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
    logic          overrun_q, overrun_d;

    assign rx_tick = (rx_cnt_q == CNT_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_done    = 1'b0;
        if (rx_state_q != RX_IDLE && rx_state_q != RX_START)
            rx_cnt_d = rx_tick ? '0 : rx_cnt_q + CW'(1);
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q + CW'(1);
                // Mid-start check rejects glitches and re-phases the counter to mid-bit.
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_shift_d = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_d[rx_bit_q[2:0]] = sync2_q;
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = (PAR != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_par_d   = sync2_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_done    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign frame_set   = rx_done & ~sync2_q;
    assign parity_set  = rx_done & (PAR != PAR_NONE) &
                         (rx_par_q != parity_bit(rx_shift_q, PAR));
    assign overrun_set = rx_done & rx_fifo_full & ~rd_i;

    assign frame_err_d  = (frame_err_q  & ~clear_err_i) | frame_set;
    assign parity_err_d = (parity_err_q & ~clear_err_i) | parity_set;
    assign overrun_d    = (overrun_q    & ~clear_err_i) | overrun_set;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= rx_line;
            sync2_q      <= sync1_q;
            rx_prev_q    <= sync2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_q     <= rx_par_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .reset_ni (reset_ni),
        .push     (rx_done),
        .pop      (rd_i),
        .din      (rx_shift_q[DATA_BITS-1:0]),
        .dout     (rx_fifo_dout),
        .empty    (rx_fifo_empty),
        .full     (rx_fifo_full)
    );

    assign tx_o         = tx_q;
    assign rx_data_o    = MB'(rx_fifo_dout);
    assign rx_valid_o   = ~rx_fifo_empty;
    assign tx_full_o    = tx_fifo_full;
    assign busy_o       = (tx_state_q != TX_IDLE) | ~tx_fifo_empty;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
    assign tx_state_o   = tx_state_q;
    assign rx_state_o   = rx_state_q;

endmodule
